// File: rtl/alu_rsp.sv
// alu_rsp: two-stage pipelined ALU with valid/ready request and response ports.
// Stage 1 captures operands and function code. Stage 2 holds the result and flags
// until the consumer takes them.
// Optional feature: define ALU_RSP_FLAGS_EN to add the carry (o_rsp_c) and
// signed-overflow (o_rsp_v) outputs. The default build omits both ports.
module alu_rsp #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [WIDTH-1:0] i_req_a,
   input  logic [WIDTH-1:0] i_req_b,
   input  logic [2:0]       i_req_f,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic [WIDTH-1:0] o_rsp_y,
   output logic             o_rsp_z,
   output logic             o_rsp_err
`ifdef ALU_RSP_FLAGS_EN
   ,
   output logic             o_rsp_c,
   output logic             o_rsp_v
`endif
);

   localparam logic [2:0] F_AND  = 3'b000;
   localparam logic [2:0] F_OR   = 3'b001;
   localparam logic [2:0] F_ADD  = 3'b010;
   localparam logic [2:0] F_ANDN = 3'b100;
   localparam logic [2:0] F_ORN  = 3'b101;
   localparam logic [2:0] F_SUB  = 3'b110;
   localparam logic [2:0] F_SLT  = 3'b111;

   // Stage 1 registers
   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [2:0]       r_s1_f;

   // Stage 2 registers (drive the response port directly)
   logic             r_s2_valid;
   logic [WIDTH-1:0] r_y;
   logic             r_z;
   logic             r_err;

   // Held low through reset so req_ready only rises on the first edge after release.
   logic             r_ready_en;

   logic             w_s2_ready;
   logic             w_s2_load;
   logic             w_req_ready;
   logic             w_req_fire;
   logic [WIDTH-1:0] w_add;
   logic [WIDTH-1:0] w_sub;
   logic             w_v_sub;
   logic             w_slt;
   logic [WIDTH-1:0] w_y_next;
   logic             w_err_next;

   // S2 can take new data when empty or when its current result leaves this cycle.
   assign w_s2_ready  = !r_s2_valid || i_rsp_ready;
   assign w_s2_load   = r_s1_valid && w_s2_ready;
   // Ready depends only on registered state and i_rsp_ready, never on i_req_valid.
   assign w_req_ready = r_ready_en && (!r_s1_valid || w_s2_ready);
   assign w_req_fire  = i_req_valid && w_req_ready;

   assign o_req_ready = w_req_ready;
   assign o_rsp_valid = r_s2_valid;
   assign o_rsp_y     = r_y;
   assign o_rsp_z     = r_z;
   assign o_rsp_err   = r_err;

   assign w_add   = r_s1_a + r_s1_b;
   assign w_sub   = r_s1_a - r_s1_b;
   // Subtraction overflows when operand signs differ and the result sign differs from a.
   assign w_v_sub = (r_s1_a[WIDTH-1] ^ r_s1_b[WIDTH-1]) & (w_sub[WIDTH-1] ^ r_s1_a[WIDTH-1]);
   // Signed less-than: sign of the difference, corrected when the subtraction overflowed.
   assign w_slt   = w_sub[WIDTH-1] ^ w_v_sub;

   // Result selection by function code; the one unassigned code flags an error.
   always_comb begin
      w_y_next   = '0;
      w_err_next = 1'b0;
      case (r_s1_f)
         F_AND:   w_y_next = r_s1_a & r_s1_b;
         F_OR:    w_y_next = r_s1_a | r_s1_b;
         F_ADD:   w_y_next = w_add;
         F_ANDN:  w_y_next = r_s1_a & ~r_s1_b;
         F_ORN:   w_y_next = r_s1_a | ~r_s1_b;
         F_SUB:   w_y_next = w_sub;
         F_SLT:   w_y_next = {{(WIDTH-1){1'b0}}, w_slt};
         default: begin
            w_y_next   = '0;
            w_err_next = 1'b1;
         end
      endcase
   end

   // Ready enable: cleared by reset, set on every clock thereafter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ready_en <= 1'b0;
      else        r_ready_en <= 1'b1;
   end

   // Stage 1: capture an accepted request, or empty when its content moves to S2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_f     <= '0;
      end else if (w_req_fire) begin
         r_s1_valid <= 1'b1;
         r_s1_a     <= i_req_a;
         r_s1_b     <= i_req_b;
         r_s1_f     <= i_req_f;
      end else if (w_s2_load) begin
         r_s1_valid <= 1'b0;
      end
   end

   // Stage 2: load a new result when free; data only changes on a load so it is
   // stable while stalled and keeps its last value when empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_y        <= '0;
         r_z        <= 1'b0;
         r_err      <= 1'b0;
      end else if (w_s2_ready) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_y   <= w_y_next;
            r_z   <= (w_y_next == '0);
            r_err <= w_err_next;
         end
      end
   end

`ifdef ALU_RSP_FLAGS_EN
   logic w_v_add;
   logic w_c_next;
   logic w_v_next;
   logic r_c;
   logic r_v;

   // Addition overflows when both operands share a sign that the sum does not.
   assign w_v_add = ~(r_s1_a[WIDTH-1] ^ r_s1_b[WIDTH-1]) & (w_add[WIDTH-1] ^ r_s1_a[WIDTH-1]);

   // Carry/overflow only meaningful for add and subtract; zero for everything else.
   always_comb begin
      w_c_next = 1'b0;
      w_v_next = 1'b0;
      if (r_s1_f == F_ADD) begin
         w_c_next = (w_add < r_s1_a);     // wrapped sum means a carry out
         w_v_next = w_v_add;
      end else if (r_s1_f == F_SUB) begin
         w_c_next = (r_s1_a >= r_s1_b);   // not-borrow
         w_v_next = w_v_sub;
      end
   end

   // Flag registers follow the same load rule as the stage 2 result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c <= 1'b0;
         r_v <= 1'b0;
      end else if (w_s2_load) begin
         r_c <= w_c_next;
         r_v <= w_v_next;
      end
   end

   assign o_rsp_c = r_c;
   assign o_rsp_v = r_v;
`endif

endmodule

// File: tb/tb_alu_rsp.sv
// Testbench for alu_rsp: scoreboard queue filled at request acceptance, separate
// monitor popping at response transfer, randomized traffic plus directed cases.
// Build with or without ALU_RSP_FLAGS_EN; flag expectations follow the macro.
module tb_alu_rsp;
   localparam int W = 32;
   typedef logic [W+3:0] rsp_t;   // {y, z, err, c, v}

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid, req_ready;
   logic [W-1:0] req_a, req_b;
   logic [2:0]   req_f;
   logic         rsp_valid, rsp_ready;
   logic [W-1:0] rsp_y;
   logic         rsp_z, rsp_err, rsp_c, rsp_v;

   always #5 clk = ~clk;

   alu_rsp #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_a(req_a), .i_req_b(req_b), .i_req_f(req_f),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_y(rsp_y), .o_rsp_z(rsp_z), .o_rsp_err(rsp_err)
`ifdef ALU_RSP_FLAGS_EN
      , .o_rsp_c(rsp_c), .o_rsp_v(rsp_v)
`endif
   );
`ifndef ALU_RSP_FLAGS_EN
   assign rsp_c = 1'b0;
   assign rsp_v = 1'b0;
`endif

   rsp_t         exp_q[$];
   logic [W-1:0] seen_y[$];
   int           seen_cyc[$];
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   int           rsp_count = 0;
   bit           bp_mode = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: arithmetic on 64-bit integers straight from the function table.
   function automatic rsp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
      longint ua, ub, sa, sb, r, smax, smin;
      logic [W-1:0] y;
      logic err, c, v;
      ua = longint'(a);  ub = longint'(b);
      sa = longint'($signed(a));  sb = longint'($signed(b));
      smax = (64'sd1 <<< (W-1)) - 1;
      smin = -(64'sd1 <<< (W-1));
      y = '0; err = 1'b0; c = 1'b0; v = 1'b0;
      case (f)
         3'b000: y = a & b;
         3'b001: y = a | b;
         3'b010: begin
            r = ua + ub;  y = W'(r);
            c = (r >= (64'sd1 <<< W));
            v = ((sa + sb) > smax) || ((sa + sb) < smin);
         end
         3'b011: err = 1'b1;
         3'b100: y = a & ~b;
         3'b101: y = a | ~b;
         3'b110: begin
            r = ua - ub;  y = W'(r);
            c = (ua >= ub);
            v = ((sa - sb) > smax) || ((sa - sb) < smin);
         end
         default: y = (sa < sb) ? W'(1) : W'(0);
      endcase
`ifndef ALU_RSP_FLAGS_EN
      c = 1'b0; v = 1'b0;
`endif
      return {y, (y == '0), err, c, v};
   endfunction

   // Scoreboard feed: a request transfers on the coming edge.
   always @(negedge clk)
      if (rst_n && req_valid && req_ready)
         exp_q.push_back(model(req_a, req_b, req_f));

   // Monitor: a response transfers on the coming edge.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp actual=y:%h required=no response", rsp_y);
         end else begin
            chk("rsp", {rsp_y, rsp_z, rsp_err, rsp_c, rsp_v}, exp_q.pop_front());
            rsp_count++;
            seen_y.push_back(rsp_y);
            seen_cyc.push_back(cyc);
            $display("rsp %0d: y=%h z=%b err=%b c=%b v=%b", rsp_count, rsp_y, rsp_z, rsp_err, rsp_c, rsp_v);
         end
      end
   end

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
      req_valid = 1'b1; req_a = a; req_b = b; req_f = f;
   endtask

   task automatic wait_accept();
      bit ok = 1'b0;
      int n = 0;
      while (!ok) begin
         @(negedge clk); ok = req_ready;
         @(posedge clk); #1;
         if (bp_mode) rsp_ready = ($urandom_range(0, 3) != 0);
         n++;
         if (!ok && n > 200) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=not accepted required=accepted within 200 cycles");
            ok = 1'b1;
         end
      end
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
      drive(a, b, f);
      wait_accept();
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
         if (bp_mode) rsp_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      bp_mode = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk({name, "_queue_empty"}, exp_q.size(), 0);
      chk({name, "_rsp_valid_low"}, rsp_valid, 0);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return {1'b1, {(W-1){1'b0}}};
         3: return {1'b0, {(W-1){1'b1}}};
         default: return W'($urandom);
      endcase
   endfunction

   initial begin : main
      int n;
      bit v;
      logic [W-1:0] y_hold;
      rst_n = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_f = '0; rsp_ready = 1'b0;
      #1 rst_n = 1'b0;
      #20;
      chk("reset_outputs", {rsp_valid, req_ready, rsp_y, rsp_z, rsp_err, rsp_c, rsp_v}, 0);
      @(negedge clk); rst_n = 1'b1;
      #1 chk("ready_before_first_edge", req_ready, 0);
      @(posedge clk); #1;
      chk("ready_after_first_edge", req_ready, 1);
      chk("idle_rsp_valid", rsp_valid, 0);
      rsp_ready = 1'b1;

      // Wrapping add and latency measured in edges from acceptance to transfer
      send(32'h0000_0001, 32'hFFFF_FFFF, 3'b010);
      req_valid = 1'b0;
      n = 0; v = 1'b0;
      while (!v && n < 10) begin
         @(negedge clk); v = rsp_valid;
         if (v) begin
            chk("add_wrap_yzerr", {rsp_y, rsp_z, rsp_err}, {32'h0, 1'b1, 1'b0});
`ifdef ALU_RSP_FLAGS_EN
            chk("add_wrap_cv", {rsp_c, rsp_v}, 2'b10);
`endif
         end
         @(posedge clk); n++;
      end
      #1 chk("latency_edges", n, 2);
      idle(2);

      // Signed less-than including the overflow case
      seen_y.delete(); seen_cyc.delete();
      send(32'h0000_0000, 32'hFFFF_FFFF, 3'b111);
      send(32'hFFFF_FFFF, 32'h0000_0000, 3'b111);
      send(32'h8000_0000, 32'h7FFF_FFFF, 3'b111);
      drain("slt");
      chk("slt_count", seen_y.size(), 3);
      if (seen_y.size() == 3) chk("slt_values", {seen_y[0], seen_y[1], seen_y[2]}, {32'd0, 32'd1, 32'd1});

      // Back-to-back throughput
      seen_y.delete(); seen_cyc.delete();
      send(32'h1234_5678, 32'h8765_4321, 3'b000);
      send(32'h1234_5678, 32'h8765_4321, 3'b001);
      send(32'h0000_0100, 32'h0000_0001, 3'b110);
      drain("b2b");
      chk("b2b_count", seen_y.size(), 3);
      if (seen_y.size() == 3) begin
         chk("b2b_values", {seen_y[0], seen_y[1], seen_y[2]}, {32'h0224_4220, 32'h9775_5779, 32'h0000_00FF});
         chk("b2b_consecutive", {seen_cyc[1] - seen_cyc[0], seen_cyc[2] - seen_cyc[1]}, {32'd1, 32'd1});
      end

      // Illegal function code
      seen_y.delete(); seen_cyc.delete();
      send(32'hFFFF_FFFF, 32'h0000_0001, 3'b011);
      drain("illegal");
      chk("illegal_count", seen_y.size(), 1);

      // Backpressure: two accepted, third blocked, outputs frozen
      seen_y.delete(); seen_cyc.delete();
      rsp_ready = 1'b0;
      send(32'd5, 32'd3, 3'b010);
      send(32'd9, 32'd4, 3'b110);
      drive(32'hF0, 32'h0F, 3'b001);
      repeat (3) begin
         @(negedge clk);
         chk("bp_req_ready_low", req_ready, 0);
         chk("bp_rsp_y_stable", {rsp_valid, rsp_y}, {1'b1, 32'd8});
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_accept();
      drain("bp");
      chk("bp_delivered", seen_y.size(), 3);
      if (seen_y.size() == 3) chk("bp_order", {seen_y[0], seen_y[1], seen_y[2]}, {32'd8, 32'd5, 32'hFF});

      // Randomized traffic with random response backpressure
      bp_mode = 1'b1;
      for (int i = 0; i < 300; i++) begin
         send(pick(), pick(), 3'($urandom_range(0, 7)));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      drain("random");

      // Reset with both stages full
      rsp_ready = 1'b0;
      send(32'd1, 32'd2, 3'b010);
      send(32'd3, 32'd4, 3'b010);
      req_valid = 1'b0;
      @(negedge clk);
      chk("full_before_reset", {rsp_valid, req_ready}, 2'b10);
      #2 rst_n = 1'b0;
      exp_q.delete();
      #1 chk("reset_midflight_outputs", {rsp_valid, req_ready, rsp_y, rsp_z, rsp_err, rsp_c, rsp_v}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1; rsp_ready = 1'b1;
      seen_y.delete(); seen_cyc.delete();
      repeat (6) @(posedge clk);
      #1;
      chk("no_stale_rsp", seen_y.size(), 0);
      chk("post_reset_ready", req_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
